// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse scheduler: one-hot state encodings and default sizing.
package pulse_pkg;

  localparam int WW_DEF        = 16;
  localparam int LAUNCH_TO_DEF = 4;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_LAUNCH  = 4'b0010,
    S_ACTIVE  = 4'b0100,
    S_HOLDOFF = 4'b1000
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set pending bit at or after rr_ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] pending,
  input  logic [IDW-1:0] rr_ptr,
  output logic           any_valid,
  output logic [IDW-1:0] winner
);

  // Walk from the farthest offset down so the nearest candidate is written last and wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NCH]) begin
        any_valid = 1'b1;
        winner    = IDW'((int'(rr_ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shares one pulse generator among NCH requesters: latches requests, grants round-robin,
// follows the generated pulse to its end, then holds off before the next grant.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for en and a pending request
//   S_LAUNCH  | trigger issued, waiting for gen_pulse to rise (bounded)
//   S_ACTIVE  | generator pulse in progress
//   S_HOLDOFF | enforced gap after the pulse before returning to idle
module pulse_sched
  import pulse_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int IDW       = 2,
  parameter int WW        = WW_DEF,
  parameter int LAUNCH_TO = LAUNCH_TO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*WW-1:0] width_cfg,
  input  logic [WW-1:0]     holdoff_cfg,
  output logic              gen_trigger,
  output logic [WW-1:0]     gen_width,
  input  logic              gen_pulse,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    pending,
  output logic              err_timeout
);

  state_t         state_q, state_d;
  logic [NCH-1:0] pending_q, pending_d, clr;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [WW-1:0]  gen_width_q, gen_width_d;
  logic           gen_trigger_q, gen_trigger_d;
  logic [NCH-1:0] done_q, done_d;
  logic           err_q, err_d;
  logic [WW-1:0]  cnt_q, cnt_d;
  logic           any_valid;
  logic [IDW-1:0] winner;

  rr_arbiter #(.NCH(NCH), .IDW(IDW)) u_arb (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      gen_width_q   <= '0;
      gen_trigger_q <= 1'b0;
      done_q        <= '0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      gen_width_q   <= gen_width_d;
      gen_trigger_q <= gen_trigger_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    gen_width_d   = gen_width_q;
    gen_trigger_d = 1'b0;
    done_d        = '0;
    err_d         = err_q;
    cnt_d         = cnt_q;
    clr           = '0;
    case (state_q)
      S_IDLE: begin
        if (en && any_valid) begin
          state_d       = S_LAUNCH;
          grant_id_d    = winner;
          gen_width_d   = width_cfg[int'(winner)*WW +: WW];
          gen_trigger_d = 1'b1;
          clr[winner]   = 1'b1;
          rr_ptr_d      = (winner == IDW'(NCH - 1)) ? '0 : winner + 1'b1;
          cnt_d         = WW'(LAUNCH_TO);
        end
      end
      S_LAUNCH: begin
        // The trigger cycle itself is not counted against the launch window.
        if (gen_pulse) begin
          state_d = S_ACTIVE;
        end else if (!gen_trigger_q) begin
          if (cnt_q <= WW'(1)) begin
            err_d              = 1'b1;
            done_d[grant_id_q] = 1'b1;
            state_d            = S_HOLDOFF;
            cnt_d              = holdoff_cfg;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (!gen_pulse) begin
          done_d[grant_id_q] = 1'b1;
          state_d            = S_HOLDOFF;
          cnt_d              = holdoff_cfg;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A new request in the grant cycle keeps the bit set.
    pending_d = (pending_q & ~clr) | req;
  end

  assign gen_trigger = gen_trigger_q;
  assign gen_width   = gen_width_q;
  assign grant_id    = grant_id_q;
  assign done        = done_q;
  assign pending     = pending_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_sched.sv
// Scoreboard bench for pulse_sched: a timestamp-based reference model predicts grants and
// completions; a monitor pops and compares whenever the DUT triggers or signals done.
module tb_pulse_sched;
  localparam int NCH = 4, IDW = 2, WW = 16, LTO = 4;

  logic              clk = 1'b0;
  logic              rst, en, gen_pulse;
  logic [NCH-1:0]    req;
  logic [NCH*WW-1:0] width_cfg;
  logic [WW-1:0]     holdoff_cfg;
  logic              gen_trigger, busy, err_timeout;
  logic [WW-1:0]     gen_width;
  logic [IDW-1:0]    grant_id;
  logic [NCH-1:0]    done, pending;

  always #5 clk = ~clk;

  pulse_sched #(.NCH(NCH), .IDW(IDW), .WW(WW), .LAUNCH_TO(LTO)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .width_cfg(width_cfg),
    .holdoff_cfg(holdoff_cfg), .gen_trigger(gen_trigger), .gen_width(gen_width),
    .gen_pulse(gen_pulse), .busy(busy), .grant_id(grant_id), .done(done),
    .pending(pending), .err_timeout(err_timeout)
  );

  typedef struct { int kind; int cyc; int id; int width; bit err; } ev_t;
  ev_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit rst_chk = 0, mon_on = 0;

  // reference model: pending set, pointer, and timestamps of the current service
  bit m_pend[NCH];
  int m_ptr = 0, next_free = 0, done_edge = 0, cur_id = 0;
  bit act = 0, cur_to = 0, m_err = 0;
  int ps = -10, pe = -20;
  int force_d = 0;

  function automatic void chk(string name, longint act_v, longint exp_v);
    n_chk++;
    if (act_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
  endfunction

  function automatic void bad(string name, longint act_v, longint exp_v);
    n_chk++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
  endfunction

  function automatic logic [NCH-1:0] pend_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NCH; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_edge(logic [NCH-1:0] r, bit e_n, bit rs);
    int w, wd, d, len;
    if (rs) begin
      for (int i = 0; i < NCH; i++) m_pend[i] = 1'b0;
      m_ptr = 0; next_free = cyc + 1; act = 0; m_err = 0; ps = -10; pe = -20;
      exp_q.delete();
      return;
    end
    if (act && cyc == done_edge) begin
      if (cur_to) m_err = 1'b1;
      exp_q.push_back('{1, cyc, cur_id, 0, m_err});
      act = 0;
      next_free = cyc + int'(holdoff_cfg) + 2;
    end
    if (!act && cyc >= next_free && e_n && any_pend()) begin
      w = 0;
      for (int k = 0; k < NCH; k++)
        if (m_pend[(m_ptr + k) % NCH]) begin w = (m_ptr + k) % NCH; break; end
      m_pend[w] = 1'b0;
      m_ptr = (w + 1) % NCH;
      wd = int'(width_cfg[w*WW +: WW]);
      d = (force_d != 0) ? force_d : (($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(1, 4)));
      force_d = 0;
      len = (wd == 0) ? 1 : wd;
      if (d <= LTO) begin
        ps = cyc + d; pe = cyc + d + len - 1; done_edge = cyc + d + len + 1; cur_to = 0;
      end else begin
        ps = -10; pe = -20; done_edge = cyc + LTO + 1; cur_to = 1;
      end
      act = 1; cur_id = w;
      exp_q.push_back('{0, cyc, w, wd, m_err});
    end
    for (int i = 0; i < NCH; i++) if (r[i]) m_pend[i] = 1'b1;
  endfunction

  task automatic step(input logic [NCH-1:0] r, input bit e_n, input bit rs);
    req = r; en = e_n; rst = rs;
    @(posedge clk);
    cyc++;
    model_edge(r, e_n, rs);
    #1;
    gen_pulse = (cyc >= ps && cyc <= pe);
    rst_chk = rs;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!act && cyc >= next_free && exp_q.size() == 0 && !any_pend()) break;
      step('0, 1'b1, 1'b0);
    end
    step('0, 1'b1, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_active(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (act && ps > 0 && cyc > ps && cyc < pe) break;
      step('0, 1'b1, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (rst_chk) begin
        chk("reset_outputs", {gen_trigger, gen_width, grant_id, done, busy, err_timeout, pending}, 0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          bad(exp_q[0].kind == 0 ? "missed_trigger" : "missed_done", -1, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        if (gen_trigger) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == 0) begin
            e = exp_q.pop_front();
            chk("grant_id", grant_id, e.id);
            chk("gen_width", gen_width, e.width);
          end else bad("unexpected_trigger", grant_id, -1);
        end
        if (done != '0) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == 1) begin
            e = exp_q.pop_front();
            chk("done_vec", done, 1 << e.id);
            chk("err_timeout", err_timeout, e.err);
          end else bad("unexpected_done", done, 0);
        end
        chk("pending", pending, pend_vec());
        chk("busy", busy, (act || cyc < next_free - 1));
      end
    end
  end

  initial begin
    logic [NCH-1:0] r;
    bit en_v;
    rst = 1; en = 0; req = '0; gen_pulse = 0; holdoff_cfg = 3;
    for (int i = 0; i < NCH; i++) width_cfg[i*WW +: WW] = WW'($urandom_range(1, 6));
    mon_on = 1;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);

    // single request, 5-cycle pulse, holdoff 3
    width_cfg[2*WW +: WW] = 16'd5; holdoff_cfg = 3; force_d = 1;
    step(4'b0100, 1'b1, 1'b0);
    drain(60);

    // round robin fairness
    step(4'b1111, 1'b1, 1'b0);
    drain(150);
    step(4'b1001, 1'b1, 1'b0);
    drain(80);

    // re-request during own grant
    width_cfg[1*WW +: WW] = 16'd6; force_d = 2;
    step(4'b0010, 1'b1, 1'b0);
    wait_active(20);
    step(4'b0010, 1'b1, 1'b0);
    drain(80);

    // launch timeout, then another request still served
    force_d = 9;
    step(4'b1000, 1'b1, 1'b0);
    drain(40);
    step(4'b0001, 1'b1, 1'b0);
    drain(40);

    // enable gating, and en dropped mid-pulse
    step(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0);
    width_cfg[2*WW +: WW] = 16'd6; force_d = 1;
    step('0, 1'b1, 1'b0);
    wait_active(20);
    for (int i = 0; i < 12; i++) step('0, 1'b0, 1'b0);
    drain(40);

    // randomized traffic
    en_v = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) en_v = ~en_v;
      if ($urandom_range(0, 20) == 0) holdoff_cfg = WW'($urandom_range(0, 3));
      if ($urandom_range(0, 10) == 0)
        width_cfg[$urandom_range(0, NCH-1)*WW +: WW] = WW'($urandom_range(0, 6));
      r = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
      step(r, en_v, 1'b0);
    end
    drain(200);

    // reset mid-pulse with other requests pending, then pointer restarts at 0
    width_cfg[0] = 1'b0;
    width_cfg[0*WW +: WW] = 16'd6; force_d = 1;
    step(4'b0001, 1'b1, 1'b0);
    wait_active(20);
    step(4'b1010, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    drain(150);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
